// File: rtl/vending_pkg.sv
// Shared types and helpers for the multi-product vending machine.
// Coin codes, FSM state encoding and coin value lookup.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_1    = 2'd1;
  localparam logic [1:0] COIN_2    = 2'd2;
  localparam logic [1:0] COIN_3    = 2'd3;

  function automatic int unsigned coin_value(
    input logic [1:0]  code,
    input int unsigned v1,
    input int unsigned v2,
    input int unsigned v3
  );
    int unsigned v;
    v = 0;
    case (code)
      COIN_1:  v = v1;
      COIN_2:  v = v2;
      COIN_3:  v = v3;
      default: v = 0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-product stock counters with decrement, bulk restock
// and a sold-out flag vector.
module vm_stock_bank #(
  parameter int NUM_GOODS  = 4,
  parameter int GOODS_W    = 2,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_en,
  input  logic [GOODS_W-1:0] dec_id,
  input  logic               restock,
  output logic [NUM_GOODS-1:0] sold_out
);

  logic [STOCK_W-1:0] stock [NUM_GOODS];

  // restock overrides a same-cycle decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_GOODS; i++)
        stock[i] <= STOCK_W'(STOCK_INIT);
    end else if (restock) begin
      for (int i = 0; i < NUM_GOODS; i++)
        stock[i] <= STOCK_W'(STOCK_INIT);
    end else if (dec_en) begin
      for (int i = 0; i < NUM_GOODS; i++)
        if (dec_id == GOODS_W'(i) && stock[i] != '0)
          stock[i] <= stock[i] - STOCK_W'(1);
    end
  end

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < NUM_GOODS; i++)
      sold_out[i] = (stock[i] == '0);
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product coin vending FSM: credit accumulation, vend,
// change/refund, inactivity timeout and cancel.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int NUM_GOODS  = 4,
  parameter int GOODS_W    = (NUM_GOODS > 1) ? $clog2(NUM_GOODS) : 1,
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 99,
  parameter int COIN1_VAL  = 1,
  parameter int COIN2_VAL  = 5,
  parameter int COIN3_VAL  = 10,
  parameter logic [NUM_GOODS*CREDIT_W-1:0] PRICES =
    {8'd7, 8'd5, 8'd3, 8'd2},
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 4,
  parameter int TIMEOUT    = 60
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           coin,
  input  logic                 sel_valid,
  input  logic [GOODS_W-1:0]   sel_id,
  input  logic                 cancel,
  input  logic                 restock,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 vend_valid,
  output logic [GOODS_W-1:0]   vend_id,
  output logic                 change_valid,
  output logic [CREDIT_W-1:0]  change_amt,
  output logic                 coin_reject,
  output logic                 sel_fail,
  output logic [NUM_GOODS-1:0] sold_out,
  output logic                 busy
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [CREDIT_W:0]  coin_add;
  logic [CREDIT_W:0]  coin_sum;
  logic [CREDIT_W-1:0] price;
  logic               coin_ok;
  logic               id_ok;
  logic               sel_ok;
  logic               active;
  logic               do_cancel;
  logic               do_sel;
  logic               do_coin;
  logic               do_tmo;
  logic               has_coin;
  logic               dec_en;

  assign has_coin = (coin != COIN_NONE);
  assign coin_add = (CREDIT_W+1)'(coin_value(
    coin, COIN1_VAL, COIN2_VAL, COIN3_VAL));
  assign coin_sum = {1'b0, credit} + coin_add;
  assign coin_ok  = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);

  assign id_ok  = int'(sel_id) < NUM_GOODS;
  assign price  = id_ok ?
    PRICES[int'(sel_id)*CREDIT_W +: CREDIT_W] : '0;
  assign sel_ok = id_ok && !sold_out[sel_id] && credit >= price;

  // cancel > sel_valid > coin > timeout
  assign active    = (state == IDLE) || (state == CREDIT);
  assign do_cancel = (state == CREDIT) && cancel;
  assign do_sel    = active && !do_cancel && sel_valid;
  assign do_coin   = active && !do_cancel && !sel_valid && has_coin;
  assign do_tmo    = (state == CREDIT) && !cancel && !sel_valid &&
                     !has_coin && timer == TMR_W'(TIMEOUT - 1);
  assign dec_en    = do_sel && sel_ok;
  assign busy      = (state == VEND) || (state == CHANGE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      credit       <= '0;
      timer        <= '0;
      vend_valid   <= 1'b0;
      vend_id      <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      sel_fail     <= 1'b0;
    end else begin
      vend_valid   <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      sel_fail     <= 1'b0;
      unique case (state)
        IDLE, CREDIT: begin
          if (do_cancel || do_tmo) begin
            state        <= CHANGE;
            change_valid <= 1'b1;
            change_amt   <= credit;
            credit       <= '0;
            timer        <= '0;
            coin_reject  <= has_coin;
          end else if (do_sel) begin
            coin_reject <= has_coin;
            if (sel_ok) begin
              state      <= VEND;
              vend_valid <= 1'b1;
              vend_id    <= sel_id;
              credit     <= credit - price;
              timer      <= '0;
            end else begin
              sel_fail <= 1'b1;
            end
          end else if (do_coin) begin
            if (coin_ok) begin
              credit <= coin_sum[CREDIT_W-1:0];
              state  <= CREDIT;
              timer  <= '0;
            end else begin
              coin_reject <= 1'b1;
            end
          end else if (state == CREDIT) begin
            timer <= timer + TMR_W'(1);
          end
        end
        VEND: begin
          coin_reject <= has_coin;
          if (credit != '0) begin
            state        <= CHANGE;
            change_valid <= 1'b1;
            change_amt   <= credit;
            credit       <= '0;
          end else begin
            state <= IDLE;
          end
        end
        CHANGE: begin
          coin_reject <= has_coin;
          state       <= IDLE;
        end
      endcase
    end
  end

  vm_stock_bank #(
    .NUM_GOODS  (NUM_GOODS),
    .GOODS_W    (GOODS_W),
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT)
  ) u_stock (
    .clk      (clk),
    .rst      (rst),
    .dec_en   (dec_en),
    .dec_id   (sel_id),
    .restock  (restock),
    .sold_out (sold_out)
  );

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scenario bench for vending_machine_multi with a vend/change
// scoreboard fed at stimulus time and drained by a monitor.
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic       restock;
  logic [7:0] credit;
  logic       vend_valid;
  logic [1:0] vend_id;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       coin_reject;
  logic       sel_fail;
  logic [3:0] sold_out;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int vend_q[$];
  int change_q[$];

  always #5 clk = ~clk;

  vending_machine_multi dut (
    .clk          (clk),
    .rst          (rst),
    .coin         (coin),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .cancel       (cancel),
    .restock      (restock),
    .credit       (credit),
    .vend_valid   (vend_valid),
    .vend_id      (vend_id),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .coin_reject  (coin_reject),
    .sel_fail     (sel_fail),
    .sold_out     (sold_out),
    .busy         (busy)
  );

  // scoreboard drain
  always @(posedge clk) begin
    int e;
    #1;
    if (vend_valid) begin
      checks++;
      if (vend_q.size() == 0) begin
        failures++;
        $display("FAIL sb_vend unexpected vend id=%0d", vend_id);
      end else begin
        e = vend_q.pop_front();
        if (int'(vend_id) != e) begin
          failures++;
          $display("FAIL sb_vend_id got=%0d exp=%0d", vend_id, e);
        end
      end
    end
    if (change_valid) begin
      checks++;
      if (change_q.size() == 0) begin
        failures++;
        $display("FAIL sb_change unexpected amt=%0d", change_amt);
      end else begin
        e = change_q.pop_front();
        if (int'(change_amt) != e) begin
          failures++;
          $display("FAIL sb_change_amt got=%0d exp=%0d",
                   change_amt, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] c);
    coin = c;
    tick();
    coin = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({credit, vend_valid, change_valid, change_amt, coin_reject,
         sel_fail, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0",
               {credit, vend_valid, change_valid, change_amt});
    end
    checks++;
    if (sold_out !== 4'b0000) begin
      failures++;
      $display("FAIL reset_sold_out got=%b exp=0000", sold_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_exact();
    put_coin(2'd1);
    put_coin(2'd2);
    put_coin(2'd1);
    checks++;
    if (credit !== 8'd7) begin
      failures++;
      $display("FAIL exact_credit got=%0d exp=7", credit);
    end
    sel_valid = 1'b1;
    sel_id = 2'd3;
    vend_q.push_back(3);
    tick();
    sel_valid = 1'b0;
    checks++;
    if (!(vend_valid === 1'b1 && vend_id === 2'd3 &&
          credit === 8'd0 && busy === 1'b1)) begin
      failures++;
      $display("FAIL exact_vend got=%b/%0d/%0d exp=1/3/0",
               vend_valid, vend_id, credit);
    end
    tick();
    checks++;
    if (change_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL exact_nochange got=%b/%b exp=0/0",
               change_valid, busy);
    end
  endtask

  task automatic test_change();
    put_coin(2'd3);
    put_coin(2'd2);
    checks++;
    if (credit !== 8'd15) begin
      failures++;
      $display("FAIL chg_credit got=%0d exp=15", credit);
    end
    sel_valid = 1'b1;
    sel_id = 2'd1;
    vend_q.push_back(1);
    change_q.push_back(12);
    tick();
    sel_valid = 1'b0;
    checks++;
    if (vend_valid !== 1'b1 || credit !== 8'd12) begin
      failures++;
      $display("FAIL chg_vend got=%b/%0d exp=1/12",
               vend_valid, credit);
    end
    tick();
    checks++;
    if (!(change_valid === 1'b1 && change_amt === 8'd12 &&
          credit === 8'd0 && busy === 1'b1)) begin
      failures++;
      $display("FAIL chg_pulse got=%b/%0d exp=1/12",
               change_valid, change_amt);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || change_amt !== 8'd0) begin
      failures++;
      $display("FAIL chg_idle got=%b/%0d exp=0/0", busy, change_amt);
    end
  endtask

  task automatic test_timeout();
    int n;
    put_coin(2'd2);
    change_q.push_back(5);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (change_valid) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 60) begin
      failures++;
      $display("FAIL tmo_cycles got=%0d exp=60", n);
    end
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++;
    if (change_valid !== 1'b0 || busy !== 1'b0 ||
        credit !== 8'd0) begin
      failures++;
      $display("FAIL idle_cancel got=%b/%b exp=0/0",
               change_valid, busy);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) put_coin(2'd3);
    put_coin(2'd2);
    checks++;
    if (credit !== 8'd95) begin
      failures++;
      $display("FAIL ovf_credit got=%0d exp=95", credit);
    end
    put_coin(2'd3);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 8'd95) begin
      failures++;
      $display("FAIL ovf_reject got=%b/%0d exp=1/95",
               coin_reject, credit);
    end
    put_coin(2'd1);
    checks++;
    if (coin_reject !== 1'b0 || credit !== 8'd96) begin
      failures++;
      $display("FAIL ovf_accept got=%b/%0d exp=0/96",
               coin_reject, credit);
    end
    cancel = 1'b1;
    change_q.push_back(96);
    tick();
    cancel = 1'b0;
    tick();
  endtask

  task automatic test_sold_out();
    for (int k = 0; k < 4; k++) begin
      put_coin(2'd1);
      put_coin(2'd1);
      sel_valid = 1'b1;
      sel_id = 2'd0;
      vend_q.push_back(0);
      tick();
      sel_valid = 1'b0;
      tick();
    end
    checks++;
    if (sold_out !== 4'b0001) begin
      failures++;
      $display("FAIL so_flag got=%b exp=0001", sold_out);
    end
    put_coin(2'd1);
    put_coin(2'd1);
    sel_valid = 1'b1;
    sel_id = 2'd0;
    tick();
    sel_valid = 1'b0;
    checks++;
    if (sel_fail !== 1'b1 || credit !== 8'd2 ||
        vend_valid !== 1'b0) begin
      failures++;
      $display("FAIL so_refuse got=%b/%0d exp=1/2", sel_fail, credit);
    end
    restock = 1'b1;
    tick();
    restock = 1'b0;
    checks++;
    if (sold_out !== 4'b0000 || sel_fail !== 1'b0) begin
      failures++;
      $display("FAIL so_restock got=%b exp=0000", sold_out);
    end
    cancel = 1'b1;
    change_q.push_back(2);
    tick();
    cancel = 1'b0;
    tick();
  endtask

  task automatic test_collide_reset();
    for (int i = 0; i < 3; i++) put_coin(2'd1);
    sel_valid = 1'b1;
    sel_id = 2'd0;
    coin = 2'd2;
    vend_q.push_back(0);
    change_q.push_back(1);
    tick();
    sel_valid = 1'b0;
    coin = 2'd0;
    checks++;
    if (vend_valid !== 1'b1 || coin_reject !== 1'b1 ||
        credit !== 8'd1) begin
      failures++;
      $display("FAIL col_vend got=%b/%b/%0d exp=1/1/1",
               vend_valid, coin_reject, credit);
    end
    tick();
    checks++;
    if (change_valid !== 1'b1 || change_amt !== 8'd1) begin
      failures++;
      $display("FAIL col_change got=%b/%0d exp=1/1",
               change_valid, change_amt);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({credit, vend_valid, change_valid, change_amt, coin_reject,
         sel_fail, busy} !== '0) begin
      failures++;
      $display("FAIL rst_chg_outs got=%b/%0d exp=0/0",
               change_valid, change_amt);
    end
    tick();
    rst = 1'b0;
    put_coin(2'd3);
    sel_valid = 1'b1;
    sel_id = 2'd0;
    vend_q.push_back(0);
    tick();
    sel_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (credit !== 8'd0 || busy !== 1'b0 || sold_out !== 4'b0) begin
      failures++;
      $display("FAIL rst_vend got=%0d/%b exp=0/0", credit, busy);
    end
    tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1;
    coin = 2'd0;
    sel_valid = 1'b0;
    sel_id = 2'd0;
    cancel = 1'b0;
    restock = 1'b0;
    test_reset();
    test_exact();
    test_change();
    test_timeout();
    test_overflow();
    test_sold_out();
    test_collide_reset();
    tick();
    checks++;
    if (vend_q.size() != 0 || change_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d/%0d exp=0/0",
               vend_q.size(), change_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
